vrs_rate_combiner_pipe: RTL and testbench
=========================================

Name: vrs_rate_combiner_pipe

Overview:
- Next-generation variable-rate-shading decision stage, placed between the rasteriser fragment stream and pixel-shader dispatch.
- Combines three shading-rate sources through two programmable combiners: per-draw, per-primitive (carried with each fragment) and rate-image tiles.
- Rate-image tiles are fetched over a request/response port through a one-entry tile cache.
- Emits a valid/ready fragment stream tagged with the applied rate and a shade/skip bit, and keeps performance counters.

Parameters:
- COORD_W, 16, fragment coordinate width.
- TILE_LOG2, 4, log2 of the rate-image tile edge in pixels (16x16 tiles).
- RATE_W, 2, width of the rate code. Rate r means a 2^r x 2^r coarse block.
- MAX_RATE, 2, largest legal rate (4x4). Every source and every result is clamped to it.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cfg_enable  in  1  VRS enable; 0 forces 1x1 shading
- cfg_draw_rate  in  RATE_W  per-draw rate (A)
- cfg_comb0_op  in  3  combiner 0: A op P
- cfg_comb1_op  in  3  combiner 1: (comb0 result) op I
- cfg_img_en  in  1  use the rate image; 0 makes I = 0
- cfg_img_inval  in  1  one-cycle pulse that invalidates the tile cache
- frag_valid  in  1  fragment valid
- frag_ready  out  1  fragment accepted
- frag_x, frag_y  in  COORD_W  pixel coordinates
- frag_prim_rate  in  RATE_W  per-primitive rate (P)
- img_req_valid  out  1  tile fetch request
- img_req_ready  in  1  request accepted
- img_req_tx, img_req_ty  out  COORD_W-TILE_LOG2  tile coordinates
- img_rsp_valid  in  1  response valid, one cycle
- img_rsp_rate  in  RATE_W  tile rate (I)
- out_valid  out  1  decision valid
- out_ready  in  1  downstream ready
- out_x, out_y  out  COORD_W  fragment coordinates passed through
- out_rate  out  RATE_W  applied rate
- out_shade  out  1  1 = fragment is the anchor of its coarse block and must be shaded
- perf_frags_in  out  CNT_W  count of accepted fragments
- perf_frags_shaded  out  CNT_W  count of output handshakes with out_shade=1
- perf_img_miss  out  CNT_W  count of tile fetches issued

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0, FSM goes to IDLE, cache tag is invalid. Reset mid-fetch abandons the fetch; a later img_rsp_valid in IDLE is ignored.
- Combiner ops:
  - 0 keep (left operand).
  - 1 replace (right operand).
  - 2 min.
  - 3 max.
  - 4 sum, saturated at MAX_RATE.
  - 5-7 behave as keep.
- Inputs above MAX_RATE are clamped to MAX_RATE before combining.
- cfg_enable=0: out_rate=0, out_shade=1, no image fetch, latency 1.
- Shade rule: for rate r, out_shade = 1 when the low r bits of x and of y are all zero. r=0 always shades.
- frag_ready = (state==IDLE) && (!out_valid || out_ready).
- Tile coordinates: tx = x>>TILE_LOG2, ty = y>>TILE_LOG2. A hit requires tag_valid and a {tx,ty} tag match.
- FSM transitions:
  - IDLE, fragment accepted:
    - If image not needed (cfg_img_en=0 or cfg_enable=0) or cache hit: load the output register at the next edge, so out_valid is high in cycle N+1.
    - On a miss: latch the fragment, go to REQ.
  - REQ: hold img_req_valid=1 with constant tx/ty until img_req_ready; then increment perf_img_miss and go to WAIT.
  - WAIT: on img_rsp_valid, write the cache (tag_valid=1), load the output register with the combined result, go to IDLE. out_valid is high in the cycle after the response.
- Output register: holds out_* stable while out_valid && !out_ready. It clears only on handshake, unless it is reloaded in that same cycle (back-to-back throughput of 1/cycle on hits).
- cfg_img_inval:
  - In IDLE/REQ: clears tag_valid.
  - In WAIT: the response is still used for the pending fragment, but tag_valid stays 0.
- Config signals must be stable while out_valid or state!=IDLE; they are sampled at fragment acceptance.
- Counters wrap modulo 2^CNT_W. Simultaneous increments of different counters are independent.

Test Plan:
- Reset, cfg_enable=0, fragments (3,5) and (0,0) -> out_rate=0, out_shade=1 for both, 1-cycle latency, perf_frags_in=2, perf_frags_shaded=2, no img_req.
- draw=1, prim=2, comb0=max, cfg_img_en=0, frag (4,8) -> rate 2, shade=1; frag (6,8) -> rate 2, shade=0.
- draw=2, prim=2, comb0=sum -> saturates at rate 2.
- Miss: comb0=keep, comb1=replace, frag (17,33) -> img_req tx=1 ty=2.
  - Hold img_req_ready=0 for 3 cycles: request stays stable.
  - rsp rate 1 -> out_rate=1, shade=0 (x odd).
  - Next frag (16,32) hits: no request, shade=1, perf_img_miss=1.
- cfg_img_inval between two same-tile fragments -> second fragment refetches, perf_img_miss=2. Inval during WAIT -> the following same-tile fragment misses.
- out_ready=0 for 4 cycles with out_valid=1 -> out_* stable, frag_ready=0.
- Assert rst during WAIT -> outputs 0; a stale img_rsp_valid next cycle produces no out_valid.

Source files
------------

// File: rtl/vrs_rate_combiner_pipe.sv
// Variable-rate-shading decision stage: combines per-draw, per-primitive and
// rate-image sources and tags each fragment with its applied rate and shade bit.
module vrs_rate_combiner_pipe #(
  parameter int COORD_W   = 16,
  parameter int TILE_LOG2 = 4,
  parameter int RATE_W    = 2,
  parameter int MAX_RATE  = 2,
  parameter int CNT_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_enable,
  input  logic [RATE_W-1:0]              cfg_draw_rate,
  input  logic [2:0]                     cfg_comb0_op,
  input  logic [2:0]                     cfg_comb1_op,
  input  logic                           cfg_img_en,
  input  logic                           cfg_img_inval,
  input  logic                           frag_valid,
  output logic                           frag_ready,
  input  logic [COORD_W-1:0]             frag_x,
  input  logic [COORD_W-1:0]             frag_y,
  input  logic [RATE_W-1:0]              frag_prim_rate,
  output logic                           img_req_valid,
  input  logic                           img_req_ready,
  output logic [COORD_W-TILE_LOG2-1:0]   img_req_tx,
  output logic [COORD_W-TILE_LOG2-1:0]   img_req_ty,
  input  logic                           img_rsp_valid,
  input  logic [RATE_W-1:0]              img_rsp_rate,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COORD_W-1:0]             out_x,
  output logic [COORD_W-1:0]             out_y,
  output logic [RATE_W-1:0]              out_rate,
  output logic                           out_shade,
  output logic [CNT_W-1:0]               perf_frags_in,
  output logic [CNT_W-1:0]               perf_frags_shaded,
  output logic [CNT_W-1:0]               perf_img_miss
);

  localparam int TC_W = COORD_W - TILE_LOG2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;

  function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] r);
    return (r > RATE_W'(MAX_RATE)) ? RATE_W'(MAX_RATE) : r;
  endfunction

  function automatic logic [RATE_W-1:0] combine(input logic [2:0] op,
                                                input logic [RATE_W-1:0] a,
                                                input logic [RATE_W-1:0] b);
    logic [RATE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      3'd1:    return b;
      3'd2:    return (a < b) ? a : b;
      3'd3:    return (a > b) ? a : b;
      3'd4:    return (s > (RATE_W+1)'(MAX_RATE)) ? RATE_W'(MAX_RATE) : s[RATE_W-1:0];
      default: return a;
    endcase
  endfunction

  // Anchor of a 2^r x 2^r block: low r bits of both coordinates are zero.
  function automatic logic shade_of(input logic [RATE_W-1:0] r,
                                    input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    logic [COORD_W-1:0] mask;
    mask = ~({COORD_W{1'b1}} << r);
    return ((x | y) & mask) == '0;
  endfunction

  logic              tag_valid;
  logic [TC_W-1:0]   tag_tx, tag_ty;
  logic [RATE_W-1:0] tag_rate;
  logic              inval_seen;

  logic [COORD_W-1:0] p_x, p_y;
  logic [RATE_W-1:0]  p_c0;
  logic [2:0]         p_op1;

  logic               accept, need_img, hit, load;
  logic [TC_W-1:0]    frag_tx, frag_ty;
  logic [RATE_W-1:0]  comb0_rate, fast_rate, rsp_rate, ld_rate;
  logic [COORD_W-1:0] ld_x, ld_y;

  assign frag_ready    = (state == IDLE) && (!out_valid || out_ready);
  assign accept        = frag_valid && frag_ready;
  assign frag_tx       = frag_x[COORD_W-1:TILE_LOG2];
  assign frag_ty       = frag_y[COORD_W-1:TILE_LOG2];
  assign need_img      = cfg_enable && cfg_img_en;
  assign hit           = tag_valid && !cfg_img_inval && (tag_tx == frag_tx) && (tag_ty == frag_ty);
  assign comb0_rate    = combine(cfg_comb0_op, clamp_rate(cfg_draw_rate), clamp_rate(frag_prim_rate));
  assign fast_rate     = cfg_enable ? combine(cfg_comb1_op, comb0_rate, need_img ? tag_rate : '0) : '0;
  assign rsp_rate      = combine(p_op1, p_c0, clamp_rate(img_rsp_rate));
  assign img_req_valid = (state == REQ);
  assign img_req_tx    = p_x[COORD_W-1:TILE_LOG2];
  assign img_req_ty    = p_y[COORD_W-1:TILE_LOG2];

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ld_x      = frag_x;
    ld_y      = frag_y;
    ld_rate   = fast_rate;
    case (state)
      IDLE: begin
        if (accept) begin
          if (need_img && !hit) state_nxt = REQ;
          else                  load      = 1'b1;
        end
      end
      REQ: begin
        if (img_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (img_rsp_valid) begin
          state_nxt = IDLE;
          load      = 1'b1;
          ld_x      = p_x;
          ld_y      = p_y;
          ld_rate   = rsp_rate;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Combiner-0 result and combiner-1 op are captured at acceptance so the
  // response only needs the final combine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_x   <= '0;
      p_y   <= '0;
      p_c0  <= '0;
      p_op1 <= '0;
    end else if (state == IDLE && accept) begin
      p_x   <= frag_x;
      p_y   <= frag_y;
      p_c0  <= comb0_rate;
      p_op1 <= cfg_comb1_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid  <= 1'b0;
      tag_tx     <= '0;
      tag_ty     <= '0;
      tag_rate   <= '0;
      inval_seen <= 1'b0;
    end else begin
      inval_seen <= (state == WAIT) && !img_rsp_valid && (inval_seen || cfg_img_inval);
      if (state == WAIT && img_rsp_valid) begin
        tag_tx    <= img_req_tx;
        tag_ty    <= img_req_ty;
        tag_rate  <= clamp_rate(img_rsp_rate);
        tag_valid <= !(inval_seen || cfg_img_inval);
      end else if (cfg_img_inval) begin
        tag_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_rate  <= '0;
      out_shade <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_x     <= ld_x;
      out_y     <= ld_y;
      out_rate  <= ld_rate;
      out_shade <= shade_of(ld_rate, ld_x, ld_y);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_frags_in     <= '0;
      perf_frags_shaded <= '0;
      perf_img_miss     <= '0;
    end else begin
      if (accept)                               perf_frags_in     <= perf_frags_in + CNT_W'(1);
      if (out_valid && out_ready && out_shade)  perf_frags_shaded <= perf_frags_shaded + CNT_W'(1);
      if (state == REQ && img_req_ready)        perf_img_miss     <= perf_img_miss + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vrs_rate_combiner_pipe.sv
// Directed bench for vrs_rate_combiner_pipe with an arithmetic reference model
// and a tile-image responder whose per-tile rates are a fixed formula.
module tb_vrs_rate_combiner_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable, cfg_img_en, cfg_img_inval;
  logic [1:0]  cfg_draw_rate;
  logic [2:0]  cfg_comb0_op, cfg_comb1_op;
  logic        frag_valid, frag_ready;
  logic [15:0] frag_x, frag_y;
  logic [1:0]  frag_prim_rate;
  logic        img_req_valid, img_req_ready;
  logic [11:0] img_req_tx, img_req_ty;
  logic        img_rsp_valid;
  logic [1:0]  img_rsp_rate;
  logic        out_valid, out_ready, out_shade;
  logic [15:0] out_x, out_y;
  logic [1:0]  out_rate;
  logic [31:0] perf_frags_in, perf_frags_shaded, perf_img_miss;

  always #5 clk = ~clk;

  vrs_rate_combiner_pipe #(.COORD_W(16), .TILE_LOG2(4), .RATE_W(2), .MAX_RATE(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_draw_rate(cfg_draw_rate),
    .cfg_comb0_op(cfg_comb0_op), .cfg_comb1_op(cfg_comb1_op),
    .cfg_img_en(cfg_img_en), .cfg_img_inval(cfg_img_inval),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_prim_rate(frag_prim_rate),
    .img_req_valid(img_req_valid), .img_req_ready(img_req_ready),
    .img_req_tx(img_req_tx), .img_req_ty(img_req_ty),
    .img_rsp_valid(img_rsp_valid), .img_rsp_rate(img_rsp_rate),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_rate(out_rate), .out_shade(out_shade),
    .perf_frags_in(perf_frags_in), .perf_frags_shaded(perf_frags_shaded),
    .perf_img_miss(perf_img_miss)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_hold = 0;
  int rsp_delay = 1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {int x; int y; int rate; int shade;} exp_t;
  exp_t expq[$];
  int   reqq_tx[$], reqq_ty[$];
  int   hs_rate[$], hs_shade[$];
  int   m_tag_valid = 0, m_tx = 0, m_ty = 0;
  int   m_in = 0, m_shaded = 0, m_miss = 0;

  function automatic int clampr(input int v);
    return (v > 2) ? 2 : v;
  endfunction

  function automatic int comb(input int op, input int a, input int b);
    case (op)
      1:       return b;
      2:       return (a < b) ? a : b;
      3:       return (a > b) ? a : b;
      4:       return clampr(a + b);
      default: return a;
    endcase
  endfunction

  function automatic int img_rate(input int tx, input int ty);
    return (tx * 3 + ty) % 4;
  endfunction

  // Returns 1 when the model expects a tile fetch for this fragment.
  function automatic int model_push(input int x, input int y, input int p);
    int tx = x / 16;
    int ty = y / 16;
    int i = 0;
    int miss = 0;
    int r;
    int blk;
    exp_t e;
    if (cfg_enable && cfg_img_en) begin
      if (!(m_tag_valid != 0 && m_tx == tx && m_ty == ty)) begin
        miss = 1;
        m_tag_valid = 1;
        m_tx = tx;
        m_ty = ty;
        m_miss++;
        reqq_tx.push_back(tx);
        reqq_ty.push_back(ty);
      end
      i = clampr(img_rate(tx, ty));
    end
    r = cfg_enable ? comb(int'(cfg_comb1_op), comb(int'(cfg_comb0_op), clampr(int'(cfg_draw_rate)), clampr(p)), i) : 0;
    blk = 1 << r;
    e.x = x;
    e.y = y;
    e.rate = r;
    e.shade = ((x % blk) == 0 && (y % blk) == 0) ? 1 : 0;
    expq.push_back(e);
    m_in++;
    return miss;
  endfunction

  task automatic send(input int x, input int y, input int p);
    int n = 0;
    int miss;
    frag_x = 16'(x);
    frag_y = 16'(y);
    frag_prim_rate = 2'(p);
    frag_valid = 1'b1;
    miss = model_push(x, y, p);
    while (!frag_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", (n < 200) ? 1 : 0, 1);
    @(posedge clk); #1;
    frag_valid = 1'b0;
    if (miss != 0) begin
      chk("miss_req_valid", img_req_valid, 1);
    end else begin
      chk("lat_out_valid", out_valid, 1);
      chk("lat_out_x", out_x, x);
      chk("hit_no_req", img_req_valid, 0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", expq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_inval();
    cfg_img_inval = 1'b1;
    m_tag_valid = 0;
    @(posedge clk); #1;
    cfg_img_inval = 1'b0;
  endtask

  task automatic model_reset();
    expq.delete();
    reqq_tx.delete();
    reqq_ty.delete();
    m_tag_valid = 0;
    m_in = 0;
    m_shaded = 0;
    m_miss = 0;
  endtask

  // Compare process: every output handshake against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      hs_rate.push_back(int'(out_rate));
      hs_shade.push_back(int'(out_shade));
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got x=%0d y=%0d expected no output", out_x, out_y);
      end else begin
        e = expq.pop_front();
        chk("out_x", out_x, e.x);
        chk("out_y", out_y, e.y);
        chk("out_rate", out_rate, e.rate);
        chk("out_shade", out_shade, e.shade);
        m_shaded += e.shade;
      end
    end
  end

  // Rate-image responder.
  initial begin
    int etx, ety;
    forever begin
      @(posedge clk); #1;
      if (img_req_valid && !rst) begin
        if (reqq_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got tx=%0d ty=%0d expected no request", img_req_tx, img_req_ty);
          etx = int'(img_req_tx);
          ety = int'(img_req_ty);
        end else begin
          etx = reqq_tx.pop_front();
          ety = reqq_ty.pop_front();
        end
        chk("req_tx", img_req_tx, etx);
        chk("req_ty", img_req_ty, ety);
        for (int k = 0; k < req_hold; k++) begin
          @(posedge clk); #1;
          chk("req_hold_valid", img_req_valid, 1);
          chk("req_hold_tx", img_req_tx, etx);
          chk("req_hold_ty", img_req_ty, ety);
        end
        img_req_ready = 1'b1;
        @(posedge clk); #1;
        img_req_ready = 1'b0;
        for (int k = 0; k < rsp_delay; k++) begin
          @(posedge clk); #1;
        end
        img_rsp_rate = 2'(img_rate(etx, ety));
        img_rsp_valid = 1'b1;
        @(posedge clk); #1;
        img_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    int c0;
    rst = 1'b1;
    cfg_enable = 1'b0; cfg_img_en = 1'b0; cfg_img_inval = 1'b0;
    cfg_draw_rate = '0; cfg_comb0_op = '0; cfg_comb1_op = '0;
    frag_valid = 1'b0; frag_x = '0; frag_y = '0; frag_prim_rate = '0;
    img_req_ready = 1'b0; img_rsp_valid = 1'b0; img_rsp_rate = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rate", out_rate, 0);
    chk("rst_req_valid", img_req_valid, 0);
    chk("rst_perf_in", perf_frags_in, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // VRS disabled
    send(3, 5, 0);
    send(0, 0, 0);
    drain();
    chk("dis_rate0", hs_rate[0], 0);
    chk("dis_shade0", hs_shade[0], 1);
    chk("dis_shade1", hs_shade[1], 1);
    chk("dis_perf_in", perf_frags_in, 2);
    chk("dis_perf_shaded", perf_frags_shaded, 2);
    chk("dis_perf_miss", perf_img_miss, 0);

    // draw/prim combine without image
    cfg_enable = 1'b1; cfg_draw_rate = 2'd1; cfg_comb0_op = 3'd3; cfg_comb1_op = 3'd0;
    send(4, 8, 2);
    send(6, 8, 2);
    drain();
    chk("max_rate_a", hs_rate[2], 2);
    chk("max_shade_a", hs_shade[2], 1);
    chk("max_rate_b", hs_rate[3], 2);
    chk("max_shade_b", hs_shade[3], 0);
    cfg_draw_rate = 2'd2; cfg_comb0_op = 3'd4;
    send(8, 12, 2);
    drain();
    chk("sum_sat_rate", hs_rate[4], 2);
    cfg_draw_rate = 2'd0; cfg_comb0_op = 3'd1;
    send(5, 5, 3);
    drain();
    chk("clamp_prim_rate", hs_rate[5], 2);
    chk("clamp_prim_shade", hs_shade[5], 0);
    cfg_draw_rate = 2'd1; cfg_comb0_op = 3'd2;
    send(2, 4, 2);
    drain();
    chk("min_rate", hs_rate[6], 1);

    // rate image: miss with stalled request, then hit
    cfg_draw_rate = 2'd2; cfg_comb0_op = 3'd0; cfg_comb1_op = 3'd1; cfg_img_en = 1'b1;
    req_hold = 3; rsp_delay = 2;
    send(17, 33, 0);
    chk("miss_tx", img_req_tx, 1);
    chk("miss_ty", img_req_ty, 2);
    drain();
    chk("miss_rate", hs_rate[7], 1);
    chk("miss_shade", hs_shade[7], 0);
    req_hold = 0;
    send(16, 32, 0);
    drain();
    chk("hit_rate", hs_rate[8], 1);
    chk("hit_shade", hs_shade[8], 1);
    chk("hit_perf_miss", perf_img_miss, 1);

    // invalidation in IDLE and during WAIT
    pulse_inval();
    send(18, 34, 0);
    drain();
    chk("inval_perf_miss", perf_img_miss, 2);
    rsp_delay = 4;
    send(40, 56, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulse_inval();
    drain();
    send(41, 57, 0);
    drain();
    chk("wait_inval_perf_miss", perf_img_miss, 4);
    chk("wait_inval_shade", hs_shade[11], 0);
    send(20, 4, 0);
    drain();
    chk("clamp_img_rate", hs_rate[12], 2);

    // output backpressure
    cfg_img_en = 1'b0; cfg_comb0_op = 3'd1; cfg_comb1_op = 3'd0;
    out_ready = 1'b0;
    send(9, 9, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_x", out_x, 9);
      chk("stall_rate", out_rate, 1);
      chk("stall_frag_ready", frag_ready, 0);
    end
    out_ready = 1'b1;
    drain();

    // back-to-back hits at one per cycle
    c0 = cyc;
    send(0, 0, 1);
    send(1, 0, 1);
    send(2, 2, 1);
    send(3, 3, 0);
    chk("b2b_cycles", cyc - c0, 4);
    drain();
    chk("perf_in_model", perf_frags_in, m_in);
    chk("perf_shaded_model", perf_frags_shaded, m_shaded);
    chk("perf_miss_model", perf_img_miss, m_miss);

    // reset while waiting for a tile response
    cfg_img_en = 1'b1; cfg_comb1_op = 3'd1;
    send(100, 100, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rstw_out_valid", out_valid, 0);
    chk("rstw_req_valid", img_req_valid, 0);
    chk("rstw_out_x", out_x, 0);
    chk("rstw_perf_in", perf_frags_in, 0);
    chk("rstw_perf_miss", perf_img_miss, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("stale_rsp_no_out", out_valid, 0);
    end
    cfg_img_en = 1'b0;
    send(0, 0, 0);
    drain();
    chk("post_rst_perf_in", perf_frags_in, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
